// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   UART_CLK_HZ        system clock frequency
//   UART_BAUD          line rate
//   UART_CLKS_PER_BIT  system clocks per serial bit, rounded to nearest
//   rx_state_t         receiver FSM state encoding
`timescale 1ns/1ps

package uart_pkg;

    localparam int unsigned UART_CLK_HZ       = 25_000_000;
    localparam int unsigned UART_BAUD         = 115200;
    localparam int unsigned UART_CLKS_PER_BIT = (UART_CLK_HZ + UART_BAUD / 2) / UART_BAUD;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
//   clk, rst_n  single clock, synchronous active-low reset (storage cleared to 0)
//   push        write request; ignored when full unless a pop is accepted
//               in the same cycle
//   push_data   byte to write
//   pop         read request; ignored when empty
//   head        entry at the read pointer
//   full/empty  occupancy status
//   count       number of entries held (0..DEPTH)
// DEPTH must be a power of two, at least 2; pointers wrap naturally.
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a small receive FIFO and
// sticky error flags.
//   clk, rst_n   single system clock, synchronous active-low reset
//   rxd          asynchronous serial input, idle high
//   rx_data      byte at the FIFO head (0 after reset)
//   rx_valid     FIFO non-empty
//   rx_ready     pop request, effective only while rx_valid is high
//   fifo_count   bytes currently held
//   frame_err    sticky: a stop bit was sampled low
//   overrun      sticky: a byte arrived while the FIFO was full
//   err_clr      clears both sticky flags (a same-cycle set wins)
// FIFO_DEPTH must be a power of two, at least 2.
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    // Two-flop synchroniser, preset high so reset does not look like a start bit.
    logic rx_meta;
    logic rxs;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shreg, shreg_next;
    logic             sample;
    logic             push;
    logic             frame_set;
    logic             overrun_set;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign sample = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_WAIT_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        push       = 1'b0;
        frame_set  = 1'b0;

        // Bit timer runs only while a frame is in progress.
        if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
            cnt_next = sample ? BIT_LOAD : cnt - 1'b1;
        end

        case (state)
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_next   = HALF_LOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (rxs) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = '0;
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_next[idx] = rxs;
                    idx_next        = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (rxs) begin
                        push       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid = !fifo_empty;

    // A simultaneous pop makes room, so only an unpopped full FIFO loses the byte.
    assign overrun_set = push && fifo_full && !(rx_ready && rx_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with the default 115200/25 MHz
// timing. Expected values come from frame-level rules (queue of bytes, depth
// limit, sticky flags) kept in the bench.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int unsigned CPB   = 217;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    int total;
    int bad;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin falls at call time (just after an edge); stop sample lands on edge 2064.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d, output bit got);
        int unsigned waited;
        waited = 0;
        while (!rx_valid && waited < 10) begin
            tick(1);
            waited++;
        end
        got = rx_valid;
        d   = rx_data;
        if (got) begin
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00)   begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        tick(4);
    endtask

    task automatic test_first_byte();
        logic [7:0] d;
        bit got;
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(2063);
                total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", rx_valid); end
                tick(1);
                total++; if (rx_valid !== 1'b1)   begin bad++; $display("FAIL latency_valid got=%b want=1", rx_valid); end
                total++; if (rx_data !== 8'h55)   begin bad++; $display("FAIL first_data got=%h want=55", rx_data); end
                total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d want=1", fifo_count); end
                total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL first_frame_err got=%b want=0", frame_err); end
            end
        join
        pop_byte(d, got);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL pop_latency got=%b want=0", rx_valid); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        bit got;
        rxd = 1'b0;
        tick(50);
        rxd = 1'b1;
        tick(300);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d want=0", fifo_count); end
        send_frame(8'hA3, 1'b1);
        tick(5);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", fifo_count); end
        total++; if (rx_data !== 8'hA3)   begin bad++; $display("FAIL glitch_next_data got=%h want=a3", rx_data); end
        total++; if (frame_err !== 1'b0 || overrun !== 1'b0)
            begin bad++; $display("FAIL glitch_flags got=%b%b want=00", frame_err, overrun); end
        pop_byte(d, got);
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        bit got;
        rxd = 1'b0;
        tick(3000);
        total++; if (frame_err !== 1'b1)  begin bad++; $display("FAIL break_frame_err got=%b want=1", frame_err); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL break_count got=%0d want=0", fifo_count); end
        rxd = 1'b1;
        tick(20);
        send_frame(8'h3C, 1'b1);
        tick(5);
        pop_byte(d, got);
        total++; if (!got || d !== 8'h3C) begin bad++; $display("FAIL after_break_data got=%h valid=%b want=3c", d, got); end
        total++; if (frame_err !== 1'b1)  begin bad++; $display("FAIL frame_err_sticky got=%b want=1", frame_err); end
        pulse_clr();
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL err_clr got=%b want=0", frame_err); end
        // err_clr held across the failing stop sample: the set must win.
        fork
            send_frame(8'h99, 1'b0);
            begin
                tick(2062);
                err_clr = 1'b1;
                tick(2);
                err_clr = 1'b0;
                total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%b want=1", frame_err); end
                total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL bad_stop_count got=%0d want=0", fifo_count); end
            end
        join
        tick(20);
        pulse_clr();
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        bit got;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
        end
        tick(5);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL overrun_count got=%0d want=4", fifo_count); end
        total++; if (overrun !== 1'b1)    begin bad++; $display("FAIL overrun_flag got=%b want=1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            pop_byte(d, got);
            total++; if (!got || d !== 8'(i)) begin bad++; $display("FAIL overrun_pop%0d got=%h valid=%b want=%h", i, d, got, 8'(i)); end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL overrun_drained got=%b want=0", rx_valid); end
        pulse_clr();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b want=0", overrun); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] b [5];
        logic [7:0] d;
        bit got;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1);
        fork
            send_frame(b[4], 1'b1);
            begin
                tick(2063);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL full_pushpop_overrun got=%b want=0", overrun); end
                total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_pushpop_count got=%0d want=4", fifo_count); end
            end
        join
        for (int i = 1; i < 5; i++) begin
            pop_byte(d, got);
            total++; if (!got || d !== b[i]) begin bad++; $display("FAIL full_pushpop_pop%0d got=%h valid=%b want=%h", i, d, got, b[i]); end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL full_pushpop_drained got=%b want=0", rx_valid); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] part;
        logic [7:0] d;
        bit got;
        send_frame(8'h11, 1'b1);
        tick(10);
        part = 8'hC6;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = part[i];
            tick(CPB);
        end
        rxd   = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(60);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", fifo_count); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL midreset_valid got=%b want=0", rx_valid); end
        rxd = 1'b1;
        tick(300);
        total++; if (frame_err !== 1'b0 || fifo_count !== 3'd0)
            begin bad++; $display("FAIL midreset_quiet got=fe%b cnt%0d want=fe0 cnt0", frame_err, fifo_count); end
        send_frame(8'h50, 1'b1);
        tick(5);
        total++; if (rx_data !== 8'h50 || fifo_count !== 3'd1)
            begin bad++; $display("FAIL midreset_next got=%h cnt%0d want=50 cnt1", rx_data, fifo_count); end
        pop_byte(d, got);
    endtask

    task automatic test_random_batches();
        logic [7:0] q [$];
        logic [7:0] b;
        logic [7:0] d;
        logic       stop;
        logic       prev_bad;
        logic       fe_exp;
        logic       ov_exp;
        bit         got;
        int unsigned n;
        for (int batch = 0; batch < 2; batch++) begin
            q.delete();
            fe_exp   = 1'b0;
            ov_exp   = 1'b0;
            prev_bad = 1'b0;
            n = $urandom_range(3, 5);
            for (int unsigned f = 0; f < n; f++) begin
                b    = 8'($urandom);
                stop = ($urandom_range(0, 3) != 0);
                if (prev_bad) tick(20);
                else if ($urandom_range(0, 1) != 0) tick($urandom_range(1, 40));
                send_frame(b, stop);
                if (!stop) fe_exp = 1'b1;
                else if (q.size() < DEPTH) q.push_back(b);
                else ov_exp = 1'b1;
                prev_bad = !stop;
            end
            tick(20);
            total++; if (fifo_count !== 3'(q.size())) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", batch, fifo_count, q.size()); end
            total++; if (frame_err !== fe_exp) begin bad++; $display("FAIL rand%0d_frame_err got=%b want=%b", batch, frame_err, fe_exp); end
            total++; if (overrun !== ov_exp)   begin bad++; $display("FAIL rand%0d_overrun got=%b want=%b", batch, overrun, ov_exp); end
            while (q.size() > 0) begin
                pop_byte(d, got);
                total++; if (!got || d !== q[0]) begin bad++; $display("FAIL rand%0d_data got=%h valid=%b want=%h", batch, d, got, q[0]); end
                void'(q.pop_front());
            end
            total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rand%0d_drained got=%b want=0", batch, rx_valid); end
            pulse_clr();
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        tick(2);
        test_reset();
        test_first_byte();
        test_glitch();
        test_frame_error();
        do_reset();
        test_overrun();
        do_reset();
        test_push_pop_full();
        do_reset();
        test_reset_midframe();
        do_reset();
        test_random_batches();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART peripheral for the RV32 trial SoC. It complements the existing transmit path on `uo_out[0]`: 8N1, LSB first, 115200 baud from the 25 MHz system clock. It deserialises bytes from a `ui_in` pin into a small FIFO that the CPU bus wrapper drains through a valid/ready port. It also flags framing and overrun errors as sticky status bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 217: system clocks per bit (25 MHz / 115200).
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, input, 1: system clock. The block uses this single clock only.
- `rst_n`, input, 1: synchronous, active-low reset.
- `rxd`, input, 1: asynchronous serial input. Idle level is high.
- `rx_data`, output, 8: byte at the FIFO head.
- `rx_valid`, output, 1: FIFO is non-empty.
- `rx_ready`, input, 1: pop request. A pop takes effect only when `rx_valid` is also high.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: number of bytes currently held.
- `frame_err`, output, 1: sticky flag. Set when a stop bit is sampled low.
- `overrun`, output, 1: sticky flag. Set when a byte arrives while the FIFO is full.
- `err_clr`, input, 1: clears both sticky flags.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1. All FSM logic uses the synchronised value `rxs`.
- FSM states are WAIT_IDLE, IDLE, START, DATA, STOP.
- Reset state is WAIT_IDLE.
- WAIT_IDLE: move to IDLE on the first cycle with `rxs`=1. This prevents a line held low from being read as a start bit.
- IDLE: when `rxs`=0, load the bit counter with HALF-1 (HALF = CLKS_PER_BIT/2 = 108) and go to START.
- Counter behaviour: it decrements every cycle. A "sample" is taken on the cycle the counter reads 0, and that same cycle reloads it with CLKS_PER_BIT-1.
- START sample:
  - `rxs`=1: treat as a glitch and return to IDLE. No error is flagged.
  - `rxs`=0: clear the bit index and go to DATA.
- DATA: on each sample, shift `rxs` into bit[index] (LSB first) and increment the index. After the 8th sample, go to STOP.
- STOP sample:
  - `rxs`=1: push the byte into the FIFO and go to IDLE. If the FIFO is full and no pop happens that cycle, drop the byte and set `overrun`.
  - `rxs`=0: discard the byte, set `frame_err`, and go to WAIT_IDLE. This also covers break conditions.
- FIFO: `rx_data` is the head entry. FIFO storage resets to 0, so `rx_data` reads 0 when empty after reset; otherwise its value while empty is don't-care.
- Push and pop in the same cycle while full: both are accepted, `fifo_count` is unchanged, and no overrun is flagged.
- Push and pop in the same cycle while count is 1: the new byte becomes the head on the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: `err_clr` clears them. If a set event and `err_clr` occur in the same cycle, the set wins.
- Reset, including mid-frame, does all of the following:
  - FSM goes to WAIT_IDLE; any partial byte is lost.
  - FIFO is emptied.
  - Both flags are cleared.
  - Synchroniser flops are set to 1.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0.
- Pin-to-`rxs` delay is 2 cycles.
- Start-bit sample falls HALF cycles after IDLE detects the falling edge. Each later sample is CLKS_PER_BIT cycles after the previous one. The stop sample is therefore HALF+9·CLKS_PER_BIT = 2061 cycles after detection.
- `rx_valid` rises, and `fifo_count` increments, 1 cycle after the stop sample. For the default parameters this is exactly 2064 cycles after the `rxd` pin falls, when the line was idle-high beforehand.
- The FSM returns to IDLE mid-stop-bit, so back-to-back frames with 1 stop bit are received without loss.
- A pop updates `rx_data`, `rx_valid` and `fifo_count` on the next edge; latency is 1 cycle.
- Flags update 1 cycle after the causing sample or after `err_clr`.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - `UART_CLK_HZ` = 25_000_000;
  - `UART_BAUD` = 115200;
  - derived `UART_CLKS_PER_BIT` = 217.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push, pop, full, empty and count; no overflow write. `uart_rx` instantiates it once.

## Test plan
1. Drive byte 0x55 at 217 clocks/bit, `rx_ready`=0 → `rx_valid` rises exactly 2064 cycles after the pin falls; `rx_data`=0x55, `fifo_count`=1, `frame_err`=0.
2. Pulse `rxd` low for 50 clocks, then send 0xA3 → no byte from the glitch; the next byte is 0xA3; both flags stay 0.
3. Hold `rxd` low for 3000 clocks, then release → `frame_err`=1, `fifo_count`=0; a following byte 0x3C is received. Pulse `err_clr` → `frame_err`=0 next cycle.
4. Send 0x01 through 0x05 back-to-back with `rx_ready`=0 → `fifo_count`=4, `overrun`=1. Pops return 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
5. Fill the FIFO with 4 bytes, then assert `rx_ready` on exactly the 5th byte's stop-sample cycle → `overrun` stays 0, `fifo_count` stays 4, and the tail entry is the 5th byte.
6. Assert `rst_n`=0 for 1 cycle after 4 data bits of a frame, keeping `rxd` low → no byte and no start detection while low. After `rxd` goes high and 0x50 ('P') is sent, `rx_data`=0x50.
